// File: rtl/dec_bin_acc.sv
// Serial BCD-to-binary accumulator: digits arrive MSD-first, acc = acc*10 + digit.
// Optional saturating overflow behaviour when DEC_BIN_SAT_EN is defined (default: wrap).
module dec_bin_acc #(
    parameter int WIDTH      = 7,
    parameter int MAX_DIGITS = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [3:0]       DIG_IN,
    input  logic             DIG_VALID,
    input  logic             DIG_LAST,
    output logic             DIG_READY,
    output logic [WIDTH-1:0] BIN_OUT,
    output logic             BIN_VALID,
    input  logic             BIN_READY,
    output logic             ERR,
    output logic             OVF
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int EW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_bin_out;
    logic             r_bin_valid;
    logic             r_err;
    logic             r_ovf;

    logic             w_dig_hs;
    logic             w_first;
    logic             w_dig_bad;
    logic [3:0]       w_digit;
    logic [EW-1:0]    w_acc_ext;
    logic [EW-1:0]    w_sum;
    logic             w_step_ovf;
    logic             w_ovf_next;
    logic             w_err_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_cnt_full;
    logic             w_close;
    logic [WIDTH-1:0] w_acc_next;

    assign DIG_READY = (r_state != S_OUT);
    assign w_dig_hs  = DIG_VALID & DIG_READY;
    assign w_first   = (r_state == S_IDLE);

    // A non-BCD digit contributes zero but poisons the number through ERR.
    assign w_dig_bad = (DIG_IN > 4'd9);
    assign w_digit   = w_dig_bad ? 4'd0 : DIG_IN;

    // The first digit starts from an implicit zero, so stale acc never leaks in.
    assign w_acc_ext  = w_first ? '0 : {4'b0000, r_acc};
    assign w_sum      = (w_acc_ext << 3) + (w_acc_ext << 1) + {{(EW-4){1'b0}}, w_digit};
    assign w_step_ovf = |w_sum[EW-1:WIDTH];
    assign w_ovf_next = w_step_ovf | (~w_first & r_ovf);

    assign w_cnt_next = w_first ? CW'(1) : r_cnt + CW'(1);
    assign w_cnt_full = (w_cnt_next == CW'(MAX_DIGITS));
    assign w_close    = DIG_LAST | w_cnt_full;
    assign w_err_next = w_dig_bad | (w_cnt_full & ~DIG_LAST) | (~w_first & r_err);

`ifdef DEC_BIN_SAT_EN
    assign w_acc_next = w_ovf_next ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_acc_next = w_sum[WIDTH-1:0];
`endif

    assign BIN_OUT   = r_bin_out;
    assign BIN_VALID = r_bin_valid;
    assign ERR       = r_err;
    assign OVF       = r_ovf;

    // NOTE: state registers use non-blocking assignments so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_dig_hs) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_err <= w_err_next;
                        r_ovf <= w_ovf_next;
                        if (w_close) begin
                            r_state     <= S_OUT;
                            r_bin_out   <= w_acc_next;
                            r_bin_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_OUT: begin
                    if (BIN_READY) begin
                        r_state     <= S_IDLE;
                        r_bin_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bin_acc.sv
// Directed self-checking bench for dec_bin_acc (WIDTH=7, MAX_DIGITS=3); the expected
// results come from a digit-level reference model feeding a scoreboard queue.
module tb_dec_bin_acc;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] DIG_IN;
    logic       DIG_VALID;
    logic       DIG_LAST;
    logic       DIG_READY;
    logic [6:0] BIN_OUT;
    logic       BIN_VALID;
    logic       BIN_READY;
    logic       ERR;
    logic       OVF;

    dec_bin_acc #(.WIDTH(7), .MAX_DIGITS(3)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .DIG_IN    (DIG_IN),
        .DIG_VALID (DIG_VALID),
        .DIG_LAST  (DIG_LAST),
        .DIG_READY (DIG_READY),
        .BIN_OUT   (BIN_OUT),
        .BIN_VALID (BIN_VALID),
        .BIN_READY (BIN_READY),
        .ERR       (ERR),
        .OVF       (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int val;
        bit err;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    int m_acc = 0;
    int m_cnt = 0;
    bit m_err = 0;
    bit m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: exact decimal arithmetic, then wrap or saturate per step.
    task automatic mdl_accept(input logic [3:0] d, input logic last);
        int dd;
        int v;
        exp_t e;
        if (m_cnt == 0) begin
            m_acc = 0;
            m_err = 0;
            m_ovf = 0;
        end
        dd = (d > 9) ? 0 : int'(d);
        if (d > 9) m_err = 1;
        v = m_acc * 10 + dd;
        if (v > 127) m_ovf = 1;
`ifdef DEC_BIN_SAT_EN
        m_acc = m_ovf ? 127 : v;
`else
        m_acc = v % 128;
`endif
        m_cnt++;
        if (last || m_cnt == 3) begin
            if (!last) m_err = 1;
            e.val = m_acc;
            e.err = m_err;
            e.ovf = m_ovf;
            q.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic mdl_reset();
        q.delete();
        m_cnt = 0;
    endtask

    // Call away from a clock edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] d, input logic last);
        int n = 0;
        DIG_IN    = d;
        DIG_VALID = 1'b1;
        DIG_LAST  = last;
        while (!DIG_READY && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("dig_ready_wait", 32'(n < 50), 32'd1);
        @(posedge CLK);
        #1;
        DIG_VALID = 1'b0;
        DIG_LAST  = 1'b0;
        mdl_accept(d, last);
    endtask

    // Call right after the closing send: BIN_VALID must already be high.
    task automatic receive(input string tag);
        exp_t e;
        @(negedge CLK);
        check({tag, "_latency"}, 32'(BIN_VALID), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_value"}, 32'(BIN_OUT), 32'(e.val));
            check({tag, "_err"}, 32'(ERR), 32'(e.err));
            check({tag, "_ovf"}, 32'(OVF), 32'(e.ovf));
            check({tag, "_ready_low"}, 32'(DIG_READY), 32'd0);
            BIN_READY = 1'b1;
            @(posedge CLK);
            #1;
            BIN_READY = 1'b0;
            @(negedge CLK);
            check({tag, "_valid_drop"}, 32'(BIN_VALID), 32'd0);
            check({tag, "_out_hold"}, 32'(BIN_OUT), 32'(e.val));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t held;
        RESET_N   = 1'b0;
        DIG_IN    = 4'd0;
        DIG_VALID = 1'b0;
        DIG_LAST  = 1'b0;
        BIN_READY = 1'b0;
        #12;
        check("rst_bin_valid", 32'(BIN_VALID), 32'd0);
        check("rst_bin_out", 32'(BIN_OUT), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_dig_ready", 32'(DIG_READY), 32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        send(4'd4, 1'b0);
        send(4'd2, 1'b1);
        receive("n42");

        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd7, 1'b1);
        receive("n127");
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd8, 1'b1);
        receive("n128");
        send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b1);
        receive("n999");

        send(4'd3, 1'b0); send(4'hA, 1'b0); send(4'd5, 1'b1);
        receive("bad_digit");
        send(4'd7, 1'b1);
        receive("single");

        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0);
        receive("maxdig");

        // Back-pressure: a digit waits at the input while the result is held.
        send(4'd8, 1'b0);
        send(4'd1, 1'b1);
        DIG_IN    = 4'd6;
        DIG_VALID = 1'b1;
        DIG_LAST  = 1'b1;
        held = q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_valid", 32'(BIN_VALID), 32'd1);
            check("bp_value", 32'(BIN_OUT), 32'(held.val));
            check("bp_ready", 32'(DIG_READY), 32'd0);
        end
        BIN_READY = 1'b1;
        @(posedge CLK);
        #1;
        BIN_READY = 1'b0;
        @(negedge CLK);
        check("bp_valid_drop", 32'(BIN_VALID), 32'd0);
        check("bp_idle_ready", 32'(DIG_READY), 32'd1);
        @(posedge CLK);
        #1;
        DIG_VALID = 1'b0;
        DIG_LAST  = 1'b0;
        mdl_accept(4'd6, 1'b1);
        receive("bp_held");

        // Reset in the middle of a number.
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        RESET_N = 1'b0;
        mdl_reset();
        #1;
        check("rst_mid_valid", 32'(BIN_VALID), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_valid", 32'(BIN_VALID), 32'd0);
        end
        send(4'd5, 1'b1);
        receive("after_rst");

        // Reset while a result is being presented.
        send(4'd9, 1'b1);
        RESET_N = 1'b0;
        mdl_reset();
        #1;
        check("rst_out_valid", 32'(BIN_VALID), 32'd0);
        check("rst_out_value", 32'(BIN_OUT), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_out_after", 32'(BIN_VALID), 32'd0);
        check("rst_out_ready", 32'(DIG_READY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
